// File: rtl/tns_enc_28.sv
// Sequential 28-wire TNS encoder: greedy MSB-first subtraction of the TNS weights,
// one codeword bit per cycle, with valid/ready on both sides.

`ifndef TNS_VH
`define TNS_VH
`define BLEN10_C 26
`define TNS01_C 26'd1
`define TNS01_B 26'd2
`define TNS01_A 26'd4
`define TNS02_C 26'd7
`define TNS02_B 26'd13
`define TNS02_A 26'd24
`define TNS03_C 26'd44
`define TNS03_B 26'd81
`define TNS03_A 26'd149
`define TNS04_C 26'd274
`define TNS04_B 26'd504
`define TNS04_A 26'd927
`define TNS05_C 26'd1705
`define TNS05_B 26'd3136
`define TNS05_A 26'd5768
`define TNS06_C 26'd10609
`define TNS06_B 26'd19513
`define TNS06_A 26'd35890
`define TNS07_C 26'd66012
`define TNS07_B 26'd121415
`define TNS07_A 26'd223317
`define TNS08_C 26'd410744
`define TNS08_B 26'd755476
`define TNS08_A 26'd1389537
`define TNS09_C 26'd2555757
`define TNS09_B 26'd4700770
`define TNS09_A 26'd8646064
`define TNS10_C 26'd15902591
`endif

module tns_enc_28 #(
  parameter int CW = 28,
  parameter int DW = `BLEN10_C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] code_out,
  output logic          code_err,
  output logic          busy
);

  // Entry i is the weight of codeword bit i (same ordering as the decoder).
  localparam logic [27:0][DW-1:0] W = {
    `TNS10_C,
    `TNS09_A, `TNS09_B, `TNS09_C,
    `TNS08_A, `TNS08_B, `TNS08_C,
    `TNS07_A, `TNS07_B, `TNS07_C,
    `TNS06_A, `TNS06_B, `TNS06_C,
    `TNS05_A, `TNS05_B, `TNS05_C,
    `TNS04_A, `TNS04_B, `TNS04_C,
    `TNS03_A, `TNS03_B, `TNS03_C,
    `TNS02_A, `TNS02_B, `TNS02_C,
    `TNS01_A, `TNS01_B, `TNS01_C
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] rem, rem_nxt, w_cur;
  logic [4:0]    idx;
  logic [CW-1:0] code;
  logic          take;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  always_comb begin
    w_cur   = W[idx];
    take    = (rem >= w_cur);
    rem_nxt = take ? (rem - w_cur) : rem;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (idx == 5'd0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // code accumulates privately; code_out only updates on the final bit so a
  // partial codeword never appears on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      idx      <= '0;
      code     <= '0;
      code_out <= '0;
      code_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rem  <= data_in;
          idx  <= 5'd27;
          code <= '0;
        end
        RUN: begin
          code[idx] <= take;
          rem       <= rem_nxt;
          if (idx == 5'd0) begin
            code_out <= {code[CW-1:1], take};
            code_err <= (rem_nxt != '0);
          end else begin
            idx <= idx - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
